midi_msg_parser: RTL

//  Byte-to-message stage directly downstream of the MIDI UART receiver: consumes received bytes
//  (data + one-cycle ready strobe) and assembles complete MIDI channel-voice messages.

---
 rtl/midi_pkg.sv | 29 ++
 rtl/midi_msg_parser_if.sv | 29 ++
 rtl/midi_msg_parser.sv | 127 ++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants: status byte ranges, event type codes and parser FSM states.
// Used by the UART receiver, the message parser and the voice allocator.
package midi_pkg;

    localparam logic [7:0] VOICE_MIN = 8'h80;
    localparam logic [7:0] SYSEX     = 8'hF0;
    localparam logic [7:0] RT_MIN    = 8'hF8;

    localparam logic [2:0] EVT_NOTE_OFF   = 3'd0;
    localparam logic [2:0] EVT_NOTE_ON    = 3'd1;
    localparam logic [2:0] EVT_POLY_AT    = 3'd2;
    localparam logic [2:0] EVT_CC         = 3'd3;
    localparam logic [2:0] EVT_PROG       = 3'd4;
    localparam logic [2:0] EVT_CHAN_AT    = 3'd5;
    localparam logic [2:0] EVT_PITCH_BEND = 3'd6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWaitD1 = 2'd1,
        StWaitD2 = 2'd2,
        StSysex  = 2'd3
    } midi_state_e;

    // Program change and channel aftertouch carry a single data byte.
    function automatic logic is_one_data(input logic [2:0] evt_type);
        return (evt_type == EVT_PROG) || (evt_type == EVT_CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Event handshake between the MIDI message parser (master) and the voice allocator (slave).
interface midi_msg_parser_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_type;
    logic [3:0] evt_chan;
    logic [6:0] evt_d1;
    logic [6:0] evt_d2;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_chan,
        output evt_d1,
        output evt_d2,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_chan,
        input  evt_d1,
        input  evt_d2,
        output evt_ready
    );

endinterface

// File: rtl/midi_msg_parser.sv
// Assembles MIDI channel-voice messages from received bytes (running status, realtime, SysEx).
// Define MIDI_CHAN_FILTER_EN to add rx_chan and drop messages for other channels.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter bit VEL0_IS_OFF = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_ready,
`ifdef MIDI_CHAN_FILTER_EN
    input  logic [3:0]         rx_chan,
`endif
    midi_msg_parser_if.master  evt,
    output logic               evt_ovf,
    input  logic               ovf_clr
);

    midi_state_e state_q, state_d;
    logic [6:0]  status_q, status_d;
    logic [6:0]  d1_q, d1_d;

    logic        msg_done;
    logic        emit;
    logic [2:0]  new_type;
    logic [6:0]  new_d1;
    logic [6:0]  new_d2;

    logic        evt_valid_q;
    logic [2:0]  evt_type_q;
    logic [3:0]  evt_chan_q;
    logic [6:0]  evt_d1_q;
    logic [6:0]  evt_d2_q;
    logic        evt_ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            status_q <= '0;
            d1_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            d1_q     <= d1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        // Realtime bytes fall through untouched.
        if (rx_ready && (rx_data < RT_MIN)) begin
            if (rx_data[7]) begin
                if (rx_data < SYSEX) begin
                    status_d = rx_data[6:0];
                    state_d  = StWaitD1;
                end else begin
                    status_d = '0;
                    state_d  = (rx_data == SYSEX) ? StSysex : StIdle;
                end
            end else begin
                unique case (state_q)
                    StWaitD1: begin
                        d1_d    = rx_data[6:0];
                        state_d = is_one_data(status_q[6:4]) ? StWaitD1 : StWaitD2;
                    end
                    StWaitD2: state_d = StWaitD1;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        msg_done = rx_ready && !rx_data[7] &&
                   (((state_q == StWaitD1) && is_one_data(status_q[6:4])) ||
                    (state_q == StWaitD2));
        new_type = status_q[6:4];
        new_d1   = (state_q == StWaitD2) ? d1_q : rx_data[6:0];
        new_d2   = (state_q == StWaitD2) ? rx_data[6:0] : 7'd0;
        if (VEL0_IS_OFF && (new_type == EVT_NOTE_ON) && (new_d2 == 7'd0)) begin
            new_type = EVT_NOTE_OFF;
        end
`ifdef MIDI_CHAN_FILTER_EN
        emit = msg_done && (status_q[3:0] == rx_chan);
`else
        emit = msg_done;
`endif
    end

    // One-entry output register; a completion that finds it occupied is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_valid_q <= 1'b0;
            evt_type_q  <= '0;
            evt_chan_q  <= '0;
            evt_d1_q    <= '0;
            evt_d2_q    <= '0;
            evt_ovf_q   <= 1'b0;
        end else begin
            if (emit && (!evt_valid_q || evt.evt_ready)) begin
                evt_valid_q <= 1'b1;
                evt_type_q  <= new_type;
                evt_chan_q  <= status_q[3:0];
                evt_d1_q    <= new_d1;
                evt_d2_q    <= new_d2;
            end else if (evt_valid_q && evt.evt_ready) begin
                evt_valid_q <= 1'b0;
            end
            if (emit && evt_valid_q && !evt.evt_ready) begin
                evt_ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                evt_ovf_q <= 1'b0;
            end
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_type  = evt_type_q;
    assign evt.evt_chan  = evt_chan_q;
    assign evt.evt_d1    = evt_d1_q;
    assign evt.evt_d2    = evt_d2_q;
    assign evt_ovf       = evt_ovf_q;

endmodule
